// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared state type, frame constants and checksum for the UART frame packetiser
package uart_frame_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SEND,
      ST_WAIT_BUSY,
      ST_WAIT_IDLE
   } state_e;

   localparam int unsigned FRAME_LEN         = 5;
   localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;

   // Sync byte is deliberately not part of the sum.
   function automatic logic [7:0] frame_checksum(input logic [7:0] seq,
                                                 input logic [7:0] hi,
                                                 input logic [7:0] lo);
      return seq + hi + lo;
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous sample FIFO, power-of-two depth, push ignored when full
module sample_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q];

   // Storage array; no reset needed since reads are gated by occupancy.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   // Pointers wrap naturally; simultaneous push and pop leave occupancy unchanged.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end

endmodule

// File: rtl/uart_frame_tx.sv
// rtl/uart_frame_tx.sv - packs buffered 16-bit samples into 5-byte frames for a byte UART
module uart_frame_tx
   import uart_frame_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC_BYTE,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] sample_in,
   input  logic        sample_valid,
   output logic        sample_ready,
   output logic [0:7]  tx_data,
   output logic        send,
   input  logic        tx_busy,
   output logic        frame_busy,
   output logic        overflow,
   output logic        ack_err
);

   localparam int unsigned      CNT_W    = $clog2(ACK_TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [2:0]       IDX_LAST = 3'(FRAME_LEN - 1);

   state_e           state_q;
   logic [15:0]      sample_q;
   logic [7:0]       frame_q [FRAME_LEN];
   logic [2:0]       idx_q;
   logic [2:0]       idx_d;
   logic [7:0]       seq_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [7:0]       tx_data_q;
   logic             send_q;
   logic             frame_busy_q;
   logic             overflow_q;
   logic             ack_err_q;

   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_pop;
   logic [15:0]      fifo_rdata;

   assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty && !tx_busy;
   assign cnt_d    = cnt_q + 1'b1;
   assign idx_d    = idx_q + 3'd1;

   sample_fifo #(
      .WIDTH (16),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (sample_valid),
      .pop   (fifo_pop),
      .wdata (sample_in),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Sticky overflow: a strobe that finds the buffer full is lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_q <= 1'b0;
      end else if (sample_valid && fifo_full) begin
         overflow_q <= 1'b1;
      end
   end

   // Frame sequencer: pop, latch bytes, then one send/ack round-trip per byte.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         sample_q     <= '0;
         idx_q        <= '0;
         seq_q        <= '0;
         cnt_q        <= '0;
         tx_data_q    <= '0;
         send_q       <= 1'b0;
         frame_busy_q <= 1'b0;
         ack_err_q    <= 1'b0;
      end else begin
         send_q    <= 1'b0;
         ack_err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (fifo_pop) begin
                  sample_q     <= fifo_rdata;
                  frame_busy_q <= 1'b1;
                  state_q      <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               frame_q[0] <= SYNC_BYTE;
               frame_q[1] <= seq_q;
               frame_q[2] <= sample_q[15:8];
               frame_q[3] <= sample_q[7:0];
               frame_q[4] <= frame_checksum(seq_q, sample_q[15:8], sample_q[7:0]);
               idx_q      <= '0;
               tx_data_q  <= SYNC_BYTE;
               send_q     <= 1'b1;
               state_q    <= ST_SEND;
            end
            ST_SEND: begin
               cnt_q   <= '0;
               state_q <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               if (tx_busy) begin
                  state_q <= ST_WAIT_IDLE;
               end else if (cnt_d == CNT_LAST) begin
                  // No retry: the byte counts as sent and the frame carries on.
                  ack_err_q <= 1'b1;
                  state_q   <= ST_WAIT_IDLE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ST_WAIT_IDLE: begin
               if (!tx_busy) begin
                  if (idx_q == IDX_LAST) begin
                     seq_q        <= seq_q + 8'd1;
                     frame_busy_q <= 1'b0;
                     state_q      <= ST_IDLE;
                  end else begin
                     idx_q     <= idx_d;
                     tx_data_q <= frame_q[idx_d];
                     send_q    <= 1'b1;
                     state_q   <= ST_SEND;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign sample_ready = !fifo_full;
   assign tx_data      = tx_data_q;
   assign send         = send_q;
   assign frame_busy   = frame_busy_q;
   assign overflow     = overflow_q;
   assign ack_err      = ack_err_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb/tb_uart_frame_tx.sv - scoreboard bench for uart_frame_tx with a simple transmitter model
module tb_uart_frame_tx;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] sample_in = '0;
   logic        sample_valid = 1'b0;
   logic        sample_ready;
   logic [0:7]  tx_data;
   logic        send;
   logic        tx_busy;
   logic        frame_busy;
   logic        overflow;
   logic        ack_err;

   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;

   logic [7:0]  exp_q [$];
   logic [7:0]  exp_seq = 8'h00;
   logic [7:0]  mon_exp;

   int          send_total = 0;
   int          ack_total = 0;
   int          byte_idx = 0;
   int          last_send_cyc = 0;
   logic        prev_send = 1'b0;
   logic [7:0]  last_seq_byte = 8'h00;
   logic [7:0]  last_chk_byte = 8'h00;

   bit          tx_force = 1'b0;
   bit          tx_dead = 1'b0;
   int          busy_delay = 2;
   int          busy_hold = 10;
   int          pending = 0;
   int          hold = 0;

   uart_frame_tx dut (
      .clk          (clk),
      .reset        (reset),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .tx_data      (tx_data),
      .send         (send),
      .tx_busy      (tx_busy),
      .frame_busy   (frame_busy),
      .overflow     (overflow),
      .ack_err      (ack_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] chk8(input logic [7:0] s, input logic [15:0] v);
      return 8'(s + v[15:8] + v[7:0]);
   endfunction

   function automatic logic [15:0] sample_val(input int i);
      return 16'(i * 40503 + 16'h1357);
   endfunction

   // Transmitter model: busy rises busy_delay cycles after send and stays for busy_hold cycles.
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_force) begin
            tx_busy = 1'b1;
            hold    = 0;
            pending = 0;
         end else begin
            if (tx_busy && hold > 0) begin
               hold--;
               if (hold == 0) tx_busy = 1'b0;
            end else if (hold == 0) begin
               tx_busy = 1'b0;
            end
            if (pending > 0) begin
               pending--;
               if (pending == 0) begin
                  tx_busy = 1'b1;
                  hold    = busy_hold;
               end
            end
            if (send && !tx_dead) pending = busy_delay;
         end
      end
   end

   // Byte monitor: pops the scoreboard on every send and times ack_err against the last send.
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            byte_idx  = 0;
            prev_send = 1'b0;
         end else begin
            if (send) begin
               check("send_gap", prev_send, 0);
               if (exp_q.size() != 0) mon_exp = exp_q.pop_front();
               else                   mon_exp = 8'bx;
               check("frame_byte", tx_data, mon_exp);
               if (byte_idx == 1) last_seq_byte = tx_data;
               if (byte_idx == 4) last_chk_byte = tx_data;
               byte_idx      = (byte_idx == 4) ? 0 : byte_idx + 1;
               last_send_cyc = cyc;
               send_total++;
            end
            if (ack_err) begin
               check("ack_err_delay", cyc - last_send_cyc, 16);
               ack_total++;
            end
            prev_send = send;
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [15:0] v, input bit accept);
      sample_in    = v;
      sample_valid = 1'b1;
      if (accept) begin
         exp_q.push_back(8'hA5);
         exp_q.push_back(exp_seq);
         exp_q.push_back(v[15:8]);
         exp_q.push_back(v[7:0]);
         exp_q.push_back(chk8(exp_seq, v));
         exp_seq = exp_seq + 8'd1;
      end
      step(1);
      sample_valid = 1'b0;
   endtask

   task automatic drain(input int budget, input string tag);
      int n = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || frame_busy !== 1'b0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(n < budget), 1);
      step(1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(2);
      check("rst_tx_data", tx_data, 0);
      check("rst_send", send, 0);
      check("rst_frame_busy", frame_busy, 0);
      check("rst_overflow", overflow, 0);
      check("rst_ack_err", ack_err, 0);
      check("rst_sample_ready", sample_ready, 1);
      reset = 1'b0;
      exp_q.delete();
      exp_seq = 8'h00;
   endtask

   initial begin
      int strobe_at;
      int lat;
      int mark;
      int n;
      bit hit;

      // First frame and start latency
      do_reset();
      strobe_at = cyc;
      strobe(16'h0048, 1);
      lat = -1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (send) begin
            lat = cyc - strobe_at;
            break;
         end
      end
      check("first_send_latency", lat, 3);
      drain(200, "frame1_drain");
      check("frame1_byte_count", send_total, 5);
      check("frame1_busy_end", frame_busy, 0);
      check("frame1_chk", last_chk_byte, 8'h48);

      // Back-to-back samples
      do_reset();
      strobe(16'h1234, 1);
      strobe(16'hBEEF, 1);
      drain(400, "b2b_drain");
      check("b2b_seq", last_seq_byte, 8'h01);
      check("b2b_chk", last_chk_byte, 8'hAE);

      // Sequence wrap with a fast transmitter
      do_reset();
      busy_delay = 1;
      busy_hold  = 1;
      for (int i = 0; i < 257; i++) begin
         strobe(sample_val(i), 1);
         drain(100, "wrap_drain");
         if (i == 255) begin
            check("wrap_seq_ff", last_seq_byte, 8'hFF);
            check("wrap_chk_ff", last_chk_byte, chk8(8'hFF, sample_val(255)));
         end
      end
      check("wrap_seq_00", last_seq_byte, 8'h00);

      // Overflow while the transmitter is held busy
      busy_delay = 2;
      busy_hold  = 10;
      tx_force   = 1'b1;
      step(2);
      strobe(16'd1, 1);
      strobe(16'd2, 1);
      strobe(16'd3, 1);
      check("ovf_ready_3", sample_ready, 1);
      strobe(16'd4, 1);
      check("ovf_ready_4", sample_ready, 0);
      check("ovf_flag_4", overflow, 0);
      strobe(16'd5, 0);
      check("ovf_flag_5", overflow, 1);
      tx_force = 1'b0;
      drain(1500, "ovf_drain");
      check("ovf_sticky", overflow, 1);
      check("ovf_ready_after", sample_ready, 1);
      check("ovf_last_seq", last_seq_byte, 8'h04);

      // Transmitter never acknowledges
      tx_dead = 1'b1;
      mark    = ack_total;
      strobe(16'hC0DE, 1);
      drain(400, "tmo_drain");
      check("tmo_ack_count", ack_total - mark, 5);
      tx_dead = 1'b0;
      strobe(16'h0F0F, 1);
      drain(200, "tmo_next_drain");
      check("tmo_seq_inc", last_seq_byte, 8'h06);

      // Reset during the third byte
      strobe(16'h7E81, 1);
      n   = 0;
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge clk);
         if (send) n++;
         if (n == 3) hit = 1'b1;
      end
      check("mid_third_byte_seen", hit, 1);
      #1 reset = 1'b1;
      @(negedge clk);
      check("mid_rst_send", send, 0);
      check("mid_rst_tx_data", tx_data, 0);
      check("mid_rst_frame_busy", frame_busy, 0);
      check("mid_rst_overflow", overflow, 0);
      check("mid_rst_ready", sample_ready, 1);
      @(posedge clk);
      #1 reset = 1'b0;
      exp_q.delete();
      exp_seq = 8'h00;
      step(20);
      strobe(16'h0102, 1);
      drain(200, "post_rst_drain");
      check("post_rst_seq", last_seq_byte, 8'h00);
      check("post_rst_chk", last_chk_byte, 8'h03);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
